// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned IMEM_WORDS = 1024;
    localparam logic [31:0] NOP_WORD   = 32'h0;

    typedef enum logic {
        FETCH,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        err;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction queue with single-cycle flush; head is zero when empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    output logic                         head_valid,
    output fetch_entry_t                 head_entry,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  entries [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // Space is guaranteed by the caller's credit accounting.
    assign do_push = push && !flush;
    assign do_pop  = pop && (count_q != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) entries[wr_ptr] <= push_entry;
    end

    assign head_valid = (count_q != '0);
    assign head_entry = head_valid ? entries[rd_ptr] : '0;
    assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-based request issue, redirect with stale-response discard.
// Optional address bounds check enabled by defining FETCH_BOUNDS_CHECK_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_err
);

    localparam int unsigned   CW      = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = QUEUE_DEPTH[CW:0];

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] occupancy;
    logic [CW:0]   credit_used;
    logic [CW:0]   inflight;
    logic [31:0]   redirect_target;
    logic          oob;
    logic          req_ok;
    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_take;
    logic          err_push;
    logic          push;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    assign redirect_target = redirect_pc & ~32'h3;

`ifdef FETCH_BOUNDS_CHECK_EN
    assign oob = (fetch_pc_q[31:2] > 30'(IMEM_WORDS - 1));
`else
    assign oob = 1'b0;
`endif

    assign credit_used = {1'b0, outstanding_q} + {1'b0, occupancy};
    // Discards still in flight also hold credit so back-to-back redirects cannot overflow the counters.
    assign inflight    = {1'b0, outstanding_q} + {1'b0, discard_q};
    assign req_ok      = (state_q == FETCH) && !oob &&
                         (credit_used < DEPTH_C) && (inflight < DEPTH_C);

    assign mem_req_valid = reset && req_ok;
    assign mem_req_addr  = reset ? fetch_pc_q : '0;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign rsp_drop = mem_rsp_valid && (discard_q != '0);
    assign rsp_take = mem_rsp_valid && (discard_q == '0) && (outstanding_q != '0);
    assign err_push = oob && (state_q == FETCH) && (outstanding_q == '0) &&
                      (discard_q == '0) && (credit_used < DEPTH_C);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        push          = 1'b0;
        push_entry    = '0;
        if (redirect_valid) begin
            state_d       = FETCH;
            fetch_pc_d    = redirect_target;
            rsp_pc_d      = redirect_target;
            outstanding_d = '0;
            discard_d     = discard_q + outstanding_q + CW'(req_fire) - CW'(rsp_drop | rsp_take);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (rsp_drop) discard_d = discard_q - 1'b1;
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
            if (rsp_take) begin
                push       = 1'b1;
                push_entry = '{data: mem_rsp_data, pc: rsp_pc_q, err: 1'b0};
                rsp_pc_d   = rsp_pc_q + 32'd4;
            end else if (err_push) begin
                push       = 1'b1;
                push_entry = '{data: NOP_WORD, pc: fetch_pc_q, err: 1'b1};
                state_d    = HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (inst_ready),
        .head_valid (inst_valid),
        .head_entry (head_entry),
        .count      (occupancy)
    );

    assign inst_data = head_entry.data;
    assign inst_pc   = head_entry.pc;
    assign inst_err  = head_entry.err & BOUNDS_EN;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory responder, expected instruction stream, directed and random phases.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int unsigned QD  = 4;
    localparam logic [31:0] RPC = 32'h00000000;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_err;

    always #5 clk = ~clk;

    fetch_unit #(
        .QUEUE_DEPTH (QD),
        .RESET_PC    (RPC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc    = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C0F96;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // ---------------- memory responder ----------------
    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    pend_t       mq[$];
    int unsigned lat_min    = 1;
    int unsigned lat_max    = 1;
    int unsigned ready_pct  = 100;
    int unsigned stray_left = 0;
    int unsigned last_due   = 0;
    int unsigned fires      = 0;

    initial begin : memory
        pend_t       p;
        int unsigned due;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
            if (!reset) begin
                mq.delete();
                last_due = cyc;
                mem_req_ready = 1'b0;
            end else if (stray_left > 0) begin
                stray_left--;
                mem_req_ready = 1'b0;
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = $urandom;
            end else begin
                mem_req_ready = ($urandom_range(99) < ready_pct);
                if (mq.size() > 0 && mq[0].due <= cyc) begin
                    p = mq.pop_front();
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_word(p.addr);
                end
            end
            @(negedge clk);
            if (reset && mem_req_valid && mem_req_ready) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq.push_back('{mem_req_addr, due});
                fires++;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] next_pc      = RPC;
    bit          halted_model = 1'b0;
    int unsigned hs           = 0;
    logic [31:0] last_hs_pc   = '0;
    bit          err_seen     = 1'b0;

    // Program flow: sequential words from the current target; an out-of-range
    // address yields one error entry and the stream stops until redirected.
    function automatic void refill();
        while (exp_q.size() < 2 && !halted_model) begin
            if (BOUNDS && next_pc[31:2] > 30'd1023) begin
                exp_q.push_back('{32'h0, next_pc, 1'b1});
                halted_model = 1'b1;
            end else begin
                exp_q.push_back('{mem_word(next_pc), next_pc, 1'b0});
                next_pc = next_pc + 32'd4;
            end
        end
    endfunction

    initial begin : monitor
        exp_t        e;
        bit          was_redirect = 1'b0;
        bit          prev_hold    = 1'b0;
        logic [31:0] prev_addr    = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                exp_q.delete();
                next_pc      = RPC;
                halted_model = 1'b0;
                was_redirect = 1'b0;
                prev_hold    = 1'b0;
                continue;
            end
            if (was_redirect) check("flush_after_redirect", 96'(inst_valid), 96'(0));
            if (!inst_valid) begin
                check("idle_outputs", 96'({inst_data, inst_pc, inst_err}), 96'(0));
            end else if (inst_ready) begin
                refill();
                hs++;
                last_hs_pc = inst_pc;
                if (inst_err) err_seen = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL inst_unexpected: got pc %h data %h err %b, required no instruction", inst_pc, inst_data, inst_err);
                end else begin
                    e = exp_q.pop_front();
                    check("inst", 96'({inst_data, inst_pc, inst_err}), 96'({e.data, e.pc, e.err}));
                end
            end
            if (prev_hold) check("req_stable", 96'({mem_req_valid, mem_req_addr}), 96'({1'b1, prev_addr}));
            if (BOUNDS && mem_req_valid) check("req_in_bounds", 96'(mem_req_addr[31:2] <= 30'd1023), 96'(1));
            prev_hold = mem_req_valid && !mem_req_ready && !redirect_valid;
            prev_addr = mem_req_addr;
            if (redirect_valid) begin
                exp_q.delete();
                next_pc      = redirect_pc & ~32'h3;
                halted_model = 1'b0;
            end
            was_redirect = redirect_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic at_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        at_drive();
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        at_drive();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_hs(input int unsigned n, input string what);
        int unsigned start  = hs;
        int unsigned budget = 200;
        while (hs < start + n && budget > 0) begin
            at_sample();
            budget--;
        end
        checks++;
        if (hs < start + n) begin
            errors++;
            $display("FAIL %s: timeout, got %0d handshakes required %0d", what, hs - start, n);
        end
    endtask

    task automatic wait_mq(input int unsigned n, input string what);
        int unsigned budget = 100;
        at_sample();
        while (mq.size() != n && budget > 0) begin
            at_sample();
            budget--;
        end
        checks++;
        if (mq.size() != n) begin
            errors++;
            $display("FAIL %s: timeout, outstanding %0d required %0d", what, mq.size(), n);
        end
    endtask

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int unsigned f0;
        int unsigned vcount;
        int unsigned hs0;
        int unsigned budget;
        int unsigned hs_rand;
        logic [31:0] tgt;

        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        #1;
        check("reset_outputs", 96'({mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, inst_err}), 96'(0));
        repeat (3) at_drive();
        reset = 1'b1;

        // Core stalled: exactly QD requests fill the queue, then issue stops.
        f0 = fires;
        repeat (10) at_sample();
        check("stall_requests", 96'(fires - f0), 96'(QD));
        check("stall_req_idle", 96'(mem_req_valid), 96'(0));
        check("stall_full_valid", 96'(inst_valid), 96'(1));

        // Core ready: one instruction per cycle from a full queue.
        at_drive();
        inst_ready = 1'b1;
        vcount = 0;
        repeat (20) begin
            at_sample();
            if (inst_valid) vcount++;
        end
        check("stream_rate", 96'(vcount), 96'(20));

        // Three in flight at latency 3, then redirect to 0x100.
        lat_min = 3;
        lat_max = 3;
        wait_mq(3, "three_outstanding");
        do_redirect(32'h00000100);
        hs0 = hs;
        wait_hs(1, "after_redirect");
        if (hs > hs0) check("redirect_target", 96'(last_hs_pc), 96'(32'h100));

        // Redirect coinciding with a response and a pop.
        lat_min = 1;
        lat_max = 1;
        repeat (8) at_sample();
        budget = 50;
        while (!(inst_valid && mq.size() > 0 && mq[0].due == cyc + 1) && budget > 0) begin
            at_sample();
            budget--;
        end
        at_drive();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00000200;
        at_sample();
        check("coincide_setup", 96'({redirect_valid, mem_rsp_valid, inst_valid, inst_ready}), 96'(4'hF));
        at_drive();
        redirect_valid = 1'b0;
        hs0 = hs;
        wait_hs(1, "after_coincide");
        if (hs > hs0) check("coincide_target", 96'(last_hs_pc), 96'(32'h200));

        if (BOUNDS) begin
            // Last in-range word, then an error entry and a halt.
            err_seen = 1'b0;
            do_redirect(32'h00000FFC);
            budget = 100;
            while (!err_seen && budget > 0) begin
                at_sample();
                budget--;
            end
            check("bounds_err_seen", 96'(err_seen), 96'(1));
            f0 = fires;
            repeat (20) at_sample();
            check("halt_no_req", 96'(fires - f0), 96'(0));
            check("halt_idle", 96'(inst_valid), 96'(0));
            do_redirect(32'h00000000);
            hs0 = hs;
            wait_hs(1, "after_halt");
            if (hs > hs0) check("halt_resume", 96'(last_hs_pc), 96'(32'h0));
        end else begin
            // Address wrap from the top of the space.
            do_redirect(32'hFFFFFFF8);
            hs0 = hs;
            wait_hs(4, "wrap_stream");
            if (hs >= hs0 + 4) check("wrap_pc", 96'(last_hs_pc), 96'(32'h4));
        end

        // Reset with two requests outstanding; stray responses afterwards.
        lat_min = 3;
        lat_max = 3;
        wait_mq(2, "two_outstanding");
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", 96'({mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, inst_err}), 96'(0));
        stray_left = 4;
        repeat (2) at_sample();
        at_drive();
        reset = 1'b1;
        hs0 = hs;
        wait_hs(1, "after_reset");
        if (hs > hs0) check("restart_pc", 96'(last_hs_pc), 96'(RPC));

        // Random traffic.
        hs_rand = hs;
        repeat (800) begin
            at_drive();
            inst_ready = ($urandom_range(99) < 70);
            ready_pct  = 70;
            lat_min    = 1;
            lat_max    = 4;
            if (redirect_valid) begin
                redirect_valid = 1'b0;
            end else if ($urandom_range(99) < 4) begin
                if (BOUNDS) tgt = {20'h0, 10'($urandom_range(1023)), 2'($urandom_range(3))};
                else if ($urandom_range(9) == 0) tgt = 32'hFFFFFFF0 | 32'($urandom_range(15));
                else tgt = $urandom;
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
            end
        end
        at_drive();
        redirect_valid = 1'b0;
        repeat (5) at_sample();
        check("random_progress", 96'(hs - hs_rand > 100), 96'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, instruction queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  reset, asynchronous and active-low.
REQ-005 redirect_valid  in  1  taken branch/jump; load new fetch PC.
REQ-006 redirect_pc  in  32  new fetch PC; bits [1:0] forced to 0.
REQ-007 mem_req_valid  out  1  fetch request to instruction memory.
REQ-008 mem_req_ready  in  1  memory accepts request.
REQ-009 mem_req_addr  out  32  word-aligned fetch address.
REQ-010 mem_rsp_valid  in  1  read data returning, in request order, at least 1 cycle after acceptance.
REQ-011 mem_rsp_data  in  32  instruction word.
REQ-012 inst_valid  out  1  queue head valid toward the core.
REQ-013 inst_ready  in  1  core consumes head.
REQ-014 inst_data  out  32  head instruction.
REQ-015 inst_pc  out  32  address of head instruction.
REQ-016 inst_err  out  1  head entry is an invalid-address entry.

Function
REQ-017 Request issue: mem_req_valid=1 when state FETCH and (outstanding + occupancy) < QUEUE_DEPTH; transfer on mem_req_valid & mem_req_ready; fetch_pc += 4 on transfer.
REQ-018 mem_req_valid/mem_req_addr SHALL stay stable until accepted unless a redirect occurs.
REQ-019 Each mem_rsp_valid pushes {mem_rsp_data, pc, err=0} into the queue unless discarded; credit scheme guarantees no overflow.
REQ-020 Queue: in-order FIFO, head on inst_*; pop on inst_valid & inst_ready; push and pop in the same cycle allowed at any occupancy.
REQ-021 Empty queue: inst_valid=0, inst_data=32'h0, inst_pc=0, inst_err=0; no same-cycle bypass from mem_rsp to inst_*, so minimum latency is response cycle + 1.
REQ-022 Redirect: next cycle fetch_pc=redirect_pc, queue flushed, all outstanding requests (including one accepted in the redirect cycle) marked for discard; discard counter loaded with outstanding count.
REQ-023 Responses arriving while discard counter > 0 SHALL be dropped and decrement it; a response in the redirect cycle itself is dropped.
REQ-024 Redirect and inst handshake in same cycle: the pop completes, everything else is flushed.
REQ-025 States: FETCH (issue normally), HALT (no issue); FETCH->HALT after pushing an error entry; HALT->FETCH only on redirect; redirect has priority over all other events.
REQ-026 fetch_pc wraps from 32'hFFFFFFFC to 0 without error.
REQ-027 Counters outstanding and discard SHALL be $clog2(QUEUE_DEPTH+1) bits and never underflow.

Reset
REQ-028 On reset low: fetch_pc=RESET_PC, state FETCH, queue empty, outstanding=0, discard=0, all outputs 0, asynchronously.
REQ-029 Reset asserted mid-transaction abandons in-flight requests; responses before first post-reset request are ignored.

Configuration
REQ-030 With FETCH_BOUNDS_CHECK_EN defined: a fetch_pc[31:2] > 1023 issues no request and pushes {32'h00000000, fetch_pc, err=1}, then enters HALT.
REQ-031 Without FETCH_BOUNDS_CHECK_EN: no check, inst_err tied 0, HALT unreachable.

Structure
REQ-032 Shared package fetch_pkg holds IMEM_WORDS=1024, NOP_WORD=32'h0, state enum {FETCH, HALT} and queue entry struct {data, pc, err}.
REQ-033 Sub-module fetch_queue (parameterised FIFO with flush) SHALL hold the queue; control and counters stay in fetch_unit.

Verification
REQ-034 Reset release, memory always ready, 1-cycle latency, inst_ready=1 -> inst_pc 0,4,8,... one per cycle after initial fill.
REQ-035 inst_ready=0 for 10 cycles -> exactly QUEUE_DEPTH=4 requests issued, queue full, mem_req_valid=0 until first pop.
REQ-036 Three requests outstanding (latency 3), redirect_pc=32'h00000100 -> three stale responses dropped, next inst_pc=32'h100.
REQ-037 Redirect in same cycle as mem_rsp_valid and inst handshake -> popped entry consumed, response dropped, queue empty next cycle.
REQ-038 FETCH_BOUNDS_CHECK_EN, redirect_pc=32'h00000FFC -> instruction at 0xFFC delivered, then entry pc=32'h1000 err=1 data=0, no further requests until redirect_pc=0.
REQ-039 Assert reset with 2 outstanding requests -> outputs 0 immediately; late responses ignored; fetch restarts at RESET_PC.
